// File: rtl/alu_arbiter.sv
// Purpose: shares one external combinational ALU between two requesters (round-robin).
// Latency: request accepted at edge T, response valid from T+2; at most one op per 3 cycles.
// Backpressure: a stalled response holds the result and blocks all new requests until taken.
// Ports: clk/reset (sync, active-high); per requester p in {0,1}: req_valid_p/req_ready_p with
//   req_a_p/req_b_p/req_op_p operands, rsp_valid_p/rsp_ready_p with rsp_res_p result;
//   alu_a/alu_b/alu_op registered ALU operands, alu_res combinational ALU result; busy = not IDLE.
module alu_arbiter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid_0,
  output logic         req_ready_0,
  input  logic [W-1:0] req_a_0,
  input  logic [W-1:0] req_b_0,
  input  logic [2:0]   req_op_0,
  output logic         rsp_valid_0,
  input  logic         rsp_ready_0,
  output logic [W-1:0] rsp_res_0,
  input  logic         req_valid_1,
  output logic         req_ready_1,
  input  logic [W-1:0] req_a_1,
  input  logic [W-1:0] req_b_1,
  input  logic [2:0]   req_op_1,
  output logic         rsp_valid_1,
  input  logic         rsp_ready_1,
  output logic [W-1:0] rsp_res_1,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_op,
  input  logic [W-1:0] alu_res,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e       state_q, state_d;
  logic         last_grant_q, last_grant_d;
  logic         grant_q, grant_d;
  logic [W-1:0] alu_a_q, alu_a_d;
  logic [W-1:0] alu_b_q, alu_b_d;
  logic [2:0]   alu_op_q, alu_op_d;
  logic [W-1:0] res_q, res_d;

  logic gnt_vld;
  logic gnt_sel;

  // A lone requester always wins; on contention the port that was not served last wins.
  always_comb begin
    gnt_vld = req_valid_0 | req_valid_1;
    gnt_sel = (req_valid_0 & req_valid_1) ? ~last_grant_q : req_valid_1;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    res_d        = res_q;
    req_ready_0  = 1'b0;
    req_ready_1  = 1'b0;
    rsp_valid_0  = 1'b0;
    rsp_valid_1  = 1'b0;
    rsp_res_0    = '0;
    rsp_res_1    = '0;

    case (state_q)
      IDLE: begin
        // Ready is only raised toward a valid requester, so ready implies a handshake.
        if (gnt_vld) begin
          req_ready_0 = ~gnt_sel;
          req_ready_1 = gnt_sel;
          grant_d     = gnt_sel;
          alu_a_d     = gnt_sel ? req_a_1  : req_a_0;
          alu_b_d     = gnt_sel ? req_b_1  : req_b_0;
          alu_op_d    = gnt_sel ? req_op_1 : req_op_0;
          state_d     = EXEC;
        end
      end
      EXEC: begin
        res_d   = alu_res;
        state_d = RESP;
      end
      RESP: begin
        rsp_valid_0 = ~grant_q;
        rsp_valid_1 = grant_q;
        rsp_res_0   = grant_q ? '0 : res_q;
        rsp_res_1   = grant_q ? res_q : '0;
        // Fairness history only advances on a completed response.
        if (grant_q ? rsp_ready_1 : rsp_ready_0) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= 3'b000;
      res_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      res_q        <= res_d;
    end
  end

  assign alu_a  = alu_a_q;
  assign alu_b  = alu_b_q;
  assign alu_op = alu_op_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Purpose: self-checking bench for alu_arbiter, with a behavioural ALU attached.
// Latency: directed tests expect responses two cycles after acceptance.
// Backpressure: exercises stalled responses and contention against a transaction-level model.
module tb_alu_arbiter;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid_0, req_ready_0, rsp_valid_0, rsp_ready_0;
  logic [W-1:0] req_a_0, req_b_0, rsp_res_0;
  logic [2:0]   req_op_0;
  logic         req_valid_1, req_ready_1, rsp_valid_1, rsp_ready_1;
  logic [W-1:0] req_a_1, req_b_1, rsp_res_1;
  logic [2:0]   req_op_1;
  logic [W-1:0] alu_a, alu_b, alu_res;
  logic [2:0]   alu_op;
  logic         busy;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.W(W)) dut (
    .clk(clk), .reset(reset),
    .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_a_0(req_a_0), .req_b_0(req_b_0),
    .req_op_0(req_op_0), .rsp_valid_0(rsp_valid_0), .rsp_ready_0(rsp_ready_0), .rsp_res_0(rsp_res_0),
    .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_a_1(req_a_1), .req_b_1(req_b_1),
    .req_op_1(req_op_1), .rsp_valid_1(rsp_valid_1), .rsp_ready_1(rsp_ready_1), .rsp_res_1(rsp_res_1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_res(alu_res), .busy(busy)
  );

  // Behavioural ALU: the external unit the arbiter drives.
  function automatic logic [W-1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] op);
    case (op)
      3'b001:  return a + b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a - b;
      default: return '0;
    endcase
  endfunction

  always_comb alu_res = alu_ref(alu_a, alu_b, alu_op);

  task automatic init_inputs();
    req_valid_0 = 0; req_a_0 = 0; req_b_0 = 0; req_op_0 = 0; rsp_ready_0 = 0;
    req_valid_1 = 0; req_a_1 = 0; req_b_1 = 0; req_op_1 = 0; rsp_ready_1 = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; init_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  // Drives one operation on port p and returns the observed result and latency (no checking).
  task automatic run_op(input int p, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] op, output logic [W-1:0] res, output int lat,
                        output bit ok);
    int n;
    ok = 0; res = '0; lat = -1;
    @(negedge clk);
    if (p == 0) begin req_valid_0 = 1; req_a_0 = a; req_b_0 = b; req_op_0 = op; end
    else        begin req_valid_1 = 1; req_a_1 = a; req_b_1 = b; req_op_1 = op; end
    n = 0; #1;
    while (!((p == 0) ? req_ready_0 : req_ready_1) && n < 20) begin @(negedge clk); #1; n++; end
    if (n >= 20) begin req_valid_0 = 0; req_valid_1 = 0; return; end
    @(negedge clk);
    if (p == 0) req_valid_0 = 0; else req_valid_1 = 0;
    n = 1; #1;
    while (!((p == 0) ? rsp_valid_0 : rsp_valid_1) && n < 20) begin @(negedge clk); #1; n++; end
    if (n >= 20) return;
    lat = n;
    res = (p == 0) ? rsp_res_0 : rsp_res_1;
    if (p == 0) rsp_ready_0 = 1; else rsp_ready_1 = 1;
    @(negedge clk);
    rsp_ready_0 = 0; rsp_ready_1 = 0;
    ok = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1; init_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else pass_cnt++;
    chk_cnt++; if (req_ready_0 !== 1'b0) $display("FAIL rst_rdy0: got %b want 0", req_ready_0); else pass_cnt++;
    chk_cnt++; if (req_ready_1 !== 1'b0) $display("FAIL rst_rdy1: got %b want 0", req_ready_1); else pass_cnt++;
    chk_cnt++; if (rsp_valid_0 !== 1'b0) $display("FAIL rst_rv0: got %b want 0", rsp_valid_0); else pass_cnt++;
    chk_cnt++; if (rsp_valid_1 !== 1'b0) $display("FAIL rst_rv1: got %b want 0", rsp_valid_1); else pass_cnt++;
    chk_cnt++; if (rsp_res_0 !== 8'h00) $display("FAIL rst_res0: got %h want 00", rsp_res_0); else pass_cnt++;
    chk_cnt++; if (rsp_res_1 !== 8'h00) $display("FAIL rst_res1: got %h want 00", rsp_res_1); else pass_cnt++;
    chk_cnt++; if (alu_a !== 8'h00) $display("FAIL rst_alu_a: got %h want 00", alu_a); else pass_cnt++;
    chk_cnt++; if (alu_b !== 8'h00) $display("FAIL rst_alu_b: got %h want 00", alu_b); else pass_cnt++;
    chk_cnt++; if (alu_op !== 3'b000) $display("FAIL rst_alu_op: got %b want 000", alu_op); else pass_cnt++;
    reset = 0;
  endtask

  task automatic test_add_port0();
    @(negedge clk);
    req_valid_0 = 1; req_a_0 = 8'h05; req_b_0 = 8'h03; req_op_0 = 3'b001; #1;
    chk_cnt++; if (req_ready_0 !== 1'b1) $display("FAIL add0_rdy0: got %b want 1", req_ready_0); else pass_cnt++;
    chk_cnt++; if (req_ready_1 !== 1'b0) $display("FAIL add0_rdy1: got %b want 0", req_ready_1); else pass_cnt++;
    @(negedge clk); req_valid_0 = 0; #1;
    chk_cnt++; if (busy !== 1'b1) $display("FAIL add0_busy: got %b want 1", busy); else pass_cnt++;
    chk_cnt++; if (rsp_valid_0 !== 1'b0) $display("FAIL add0_early_rv: got %b want 0", rsp_valid_0); else pass_cnt++;
    chk_cnt++; if (alu_a !== 8'h05 || alu_b !== 8'h03 || alu_op !== 3'b001)
      $display("FAIL add0_alu_in: got %h %h %b want 05 03 001", alu_a, alu_b, alu_op); else pass_cnt++;
    @(negedge clk); #1;
    chk_cnt++; if (rsp_valid_0 !== 1'b1) $display("FAIL add0_rv0: got %b want 1", rsp_valid_0); else pass_cnt++;
    chk_cnt++; if (rsp_res_0 !== 8'h08) $display("FAIL add0_res0: got %h want 08", rsp_res_0); else pass_cnt++;
    chk_cnt++; if (rsp_valid_1 !== 1'b0 || rsp_res_1 !== 8'h00)
      $display("FAIL add0_port1_quiet: got %b %h want 0 00", rsp_valid_1, rsp_res_1); else pass_cnt++;
    rsp_ready_0 = 1;
    @(negedge clk); rsp_ready_0 = 0; #1;
    chk_cnt++; if (rsp_valid_0 !== 1'b0 || busy !== 1'b0)
      $display("FAIL add0_done: got rv=%b busy=%b want 0 0", rsp_valid_0, busy); else pass_cnt++;
  endtask

  task automatic test_port1_sub();
    logic [W-1:0] r; int lat; bit ok;
    run_op(1, 8'h03, 8'h05, 3'b100, r, lat, ok);
    chk_cnt++; if (!ok) $display("FAIL sub1_timeout: got no handshake want handshake"); else pass_cnt++;
    chk_cnt++; if (r !== 8'hFE) $display("FAIL sub1_res: got %h want fe", r); else pass_cnt++;
    chk_cnt++; if (lat !== 2) $display("FAIL sub1_lat: got %0d want 2", lat); else pass_cnt++;
    run_op(1, 8'hFF, 8'h01, 3'b001, r, lat, ok);
    chk_cnt++; if (!ok) $display("FAIL addwrap1_timeout: got no handshake want handshake"); else pass_cnt++;
    chk_cnt++; if (r !== 8'h00) $display("FAIL addwrap1_res: got %h want 00", r); else pass_cnt++;
  endtask

  task automatic test_fairness();
    int order[$];
    int n;
    do_reset();
    req_valid_0 = 1; req_a_0 = 8'hF0; req_b_0 = 8'h3C; req_op_0 = 3'b010; rsp_ready_0 = 1;
    req_valid_1 = 1; req_a_1 = 8'hF0; req_b_1 = 8'h0F; req_op_1 = 3'b011; rsp_ready_1 = 1;
    for (int i = 0; i < 13; i++) begin
      #1;
      if (req_ready_0 && req_ready_1) begin
        chk_cnt++; $display("FAIL fair_both_ready: got 1 1 want one-hot");
      end
      if (req_ready_0) order.push_back(0);
      if (req_ready_1) order.push_back(1);
      if (rsp_valid_0) begin
        chk_cnt++; if (rsp_res_0 !== 8'h30) $display("FAIL fair_res0: got %h want 30", rsp_res_0); else pass_cnt++;
      end
      if (rsp_valid_1) begin
        chk_cnt++; if (rsp_res_1 !== 8'hFF) $display("FAIL fair_res1: got %h want ff", rsp_res_1); else pass_cnt++;
      end
      @(negedge clk);
    end
    req_valid_0 = 0; req_valid_1 = 0;
    n = 0; #1;
    while (busy && n < 10) begin @(negedge clk); #1; n++; end
    rsp_ready_0 = 0; rsp_ready_1 = 0;
    chk_cnt++; if (n >= 10) $display("FAIL fair_drain: got busy want idle"); else pass_cnt++;
    chk_cnt++; if (order.size() < 4) $display("FAIL fair_count: got %0d want >=4", order.size()); else pass_cnt++;
    foreach (order[i]) begin
      chk_cnt++; if (order[i] != (i % 2)) $display("FAIL fair_order[%0d]: got %0d want %0d", i, order[i], i % 2); else pass_cnt++;
    end
  endtask

  task automatic test_stall();
    @(negedge clk);
    req_valid_0 = 1; req_a_0 = 8'h21; req_b_0 = 8'h13; req_op_0 = 3'b001; rsp_ready_0 = 0; #1;
    chk_cnt++; if (req_ready_0 !== 1'b1) $display("FAIL stall_rdy0: got %b want 1", req_ready_0); else pass_cnt++;
    @(negedge clk);
    req_valid_0 = 0;
    req_valid_1 = 1; req_a_1 = 8'h0F; req_b_1 = 8'h01; req_op_1 = 3'b100; rsp_ready_1 = 0; #1;
    chk_cnt++; if (req_ready_1 !== 1'b0) $display("FAIL stall_exec_rdy1: got %b want 0", req_ready_1); else pass_cnt++;
    @(negedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk_cnt++; if (rsp_valid_0 !== 1'b1 || rsp_res_0 !== 8'h34)
        $display("FAIL stall_hold%0d: got %b %h want 1 34", i, rsp_valid_0, rsp_res_0); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b1 || req_ready_1 !== 1'b0)
        $display("FAIL stall_block%0d: got busy=%b rdy1=%b want 1 0", i, busy, req_ready_1); else pass_cnt++;
      @(negedge clk); #1;
    end
    rsp_ready_0 = 1; #1;
    chk_cnt++; if (req_ready_1 !== 1'b0) $display("FAIL stall_handshake_rdy1: got %b want 0", req_ready_1); else pass_cnt++;
    @(negedge clk); rsp_ready_0 = 0; #1;
    chk_cnt++; if (req_ready_1 !== 1'b1 || rsp_valid_0 !== 1'b0)
      $display("FAIL stall_after: got rdy1=%b rv0=%b want 1 0", req_ready_1, rsp_valid_0); else pass_cnt++;
    @(negedge clk); req_valid_1 = 0;
    @(negedge clk); #1;
    chk_cnt++; if (rsp_valid_1 !== 1'b1 || rsp_res_1 !== 8'h0E || rsp_valid_0 !== 1'b0)
      $display("FAIL stall_port1: got %b %h rv0=%b want 1 0e 0", rsp_valid_1, rsp_res_1, rsp_valid_0); else pass_cnt++;
    rsp_ready_1 = 1;
    @(negedge clk); rsp_ready_1 = 0;
  endtask

  task automatic test_undefined_op();
    logic [W-1:0] r; int lat; bit ok;
    run_op(0, 8'h12, 8'h34, 3'b111, r, lat, ok);
    chk_cnt++; if (!ok) $display("FAIL undef_timeout: got no handshake want handshake"); else pass_cnt++;
    chk_cnt++; if (r !== 8'h00) $display("FAIL undef_res: got %h want 00", r); else pass_cnt++;
    chk_cnt++; if (lat !== 2) $display("FAIL undef_lat: got %0d want 2", lat); else pass_cnt++;
    chk_cnt++; if (alu_op !== 3'b111) $display("FAIL undef_fwd_op: got %b want 111", alu_op); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] r; int lat; bit ok;
    // Port 0 completes last, so without a reset of the fairness history port 1 would win next.
    run_op(0, 8'h01, 8'h01, 3'b001, r, lat, ok);
    chk_cnt++; if (!ok || r !== 8'h02) $display("FAIL rmid_pre: got ok=%b %h want 1 02", ok, r); else pass_cnt++;
    @(negedge clk);
    req_valid_1 = 1; req_a_1 = 8'h40; req_b_1 = 8'h02; req_op_1 = 3'b001; #1;
    chk_cnt++; if (req_ready_1 !== 1'b1) $display("FAIL rmid_rdy1: got %b want 1", req_ready_1); else pass_cnt++;
    @(negedge clk); req_valid_1 = 0; reset = 1;
    @(negedge clk); reset = 0; #1;
    chk_cnt++; if (busy !== 0 || rsp_valid_0 !== 0 || rsp_valid_1 !== 0 || rsp_res_1 !== 8'h00)
      $display("FAIL rmid_exec_out: got busy=%b rv=%b%b res1=%h want 0 00 00", busy, rsp_valid_0, rsp_valid_1, rsp_res_1); else pass_cnt++;
    chk_cnt++; if (alu_a !== 8'h00 || alu_b !== 8'h00 || alu_op !== 3'b000)
      $display("FAIL rmid_exec_alu: got %h %h %b want 00 00 000", alu_a, alu_b, alu_op); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk_cnt++; if (rsp_valid_1 !== 1'b0) $display("FAIL rmid_exec_norsp%0d: got %b want 0", i, rsp_valid_1); else pass_cnt++;
    end
    req_valid_0 = 1; req_a_0 = 8'h0A; req_b_0 = 8'h05; req_op_0 = 3'b001;
    req_valid_1 = 1; req_a_1 = 8'h0B; req_b_1 = 8'h05; req_op_1 = 3'b001; #1;
    chk_cnt++; if (req_ready_0 !== 1'b1 || req_ready_1 !== 1'b0)
      $display("FAIL rmid_exec_grant: got %b%b want 10", req_ready_0, req_ready_1); else pass_cnt++;
    @(negedge clk); req_valid_0 = 0; req_valid_1 = 0;
    @(negedge clk); #1;
    chk_cnt++; if (rsp_valid_0 !== 1'b1 || rsp_res_0 !== 8'h0F)
      $display("FAIL rmid_resp_pre: got %b %h want 1 0f", rsp_valid_0, rsp_res_0); else pass_cnt++;
    reset = 1;
    @(negedge clk); reset = 0; #1;
    chk_cnt++; if (busy !== 0 || rsp_valid_0 !== 0 || rsp_res_0 !== 8'h00 || alu_a !== 8'h00)
      $display("FAIL rmid_resp_out: got busy=%b rv0=%b res0=%h a=%h want 0 0 00 00", busy, rsp_valid_0, rsp_res_0, alu_a); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk_cnt++; if (rsp_valid_0 !== 1'b0) $display("FAIL rmid_resp_norsp%0d: got %b want 0", i, rsp_valid_0); else pass_cnt++;
    end
    req_valid_0 = 1; req_valid_1 = 1; #1;
    chk_cnt++; if (req_ready_0 !== 1'b1 || req_ready_1 !== 1'b0)
      $display("FAIL rmid_resp_grant: got %b%b want 10", req_ready_0, req_ready_1); else pass_cnt++;
    req_valid_0 = 0; req_valid_1 = 0;
  endtask

  // Transaction-level model: one op in flight at a time, response due two edges after
  // acceptance, history of the last completed port decides contention.
  task automatic test_random();
    bit           m_busy  = 0;
    int           m_owner = 0;
    int           m_age   = 0;
    int           m_last  = 1;
    logic [W-1:0] m_res   = '0;
    bit           e_rdy0, e_rdy1, e_rv0, e_rv1;
    logic [W-1:0] e_res0, e_res1;
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      req_valid_0 = ($urandom_range(0, 9) < 6); req_a_0 = W'($urandom); req_b_0 = W'($urandom);
      req_op_0 = 3'($urandom); rsp_ready_0 = ($urandom_range(0, 9) < 5);
      req_valid_1 = ($urandom_range(0, 9) < 6); req_a_1 = W'($urandom); req_b_1 = W'($urandom);
      req_op_1 = 3'($urandom); rsp_ready_1 = ($urandom_range(0, 9) < 5);
      #1;
      e_rdy0 = !m_busy && req_valid_0 && (!req_valid_1 || m_last == 1);
      e_rdy1 = !m_busy && req_valid_1 && (!req_valid_0 || m_last == 0);
      e_rv0  = m_busy && m_owner == 0 && m_age >= 2;
      e_rv1  = m_busy && m_owner == 1 && m_age >= 2;
      e_res0 = e_rv0 ? m_res : '0;
      e_res1 = e_rv1 ? m_res : '0;
      chk_cnt++; if (req_ready_0 !== e_rdy0) $display("FAIL rnd_rdy0 @%0d: got %b want %b", cyc, req_ready_0, e_rdy0); else pass_cnt++;
      chk_cnt++; if (req_ready_1 !== e_rdy1) $display("FAIL rnd_rdy1 @%0d: got %b want %b", cyc, req_ready_1, e_rdy1); else pass_cnt++;
      chk_cnt++; if (rsp_valid_0 !== e_rv0) $display("FAIL rnd_rv0 @%0d: got %b want %b", cyc, rsp_valid_0, e_rv0); else pass_cnt++;
      chk_cnt++; if (rsp_valid_1 !== e_rv1) $display("FAIL rnd_rv1 @%0d: got %b want %b", cyc, rsp_valid_1, e_rv1); else pass_cnt++;
      chk_cnt++; if (rsp_res_0 !== e_res0) $display("FAIL rnd_res0 @%0d: got %h want %h", cyc, rsp_res_0, e_res0); else pass_cnt++;
      chk_cnt++; if (rsp_res_1 !== e_res1) $display("FAIL rnd_res1 @%0d: got %h want %h", cyc, rsp_res_1, e_res1); else pass_cnt++;
      chk_cnt++; if (busy !== m_busy) $display("FAIL rnd_busy @%0d: got %b want %b", cyc, busy, m_busy); else pass_cnt++;
      if (m_busy) begin
        if ((e_rv0 && rsp_ready_0) || (e_rv1 && rsp_ready_1)) begin
          m_busy = 0; m_last = m_owner;
        end else begin
          m_age++;
        end
      end else if (e_rdy0 || e_rdy1) begin
        m_busy  = 1;
        m_age   = 1;
        m_owner = e_rdy1 ? 1 : 0;
        m_res   = e_rdy1 ? alu_ref(req_a_1, req_b_1, req_op_1) : alu_ref(req_a_0, req_b_0, req_op_0);
      end
      @(negedge clk);
    end
    init_inputs();
  endtask

  initial begin
    reset = 1;
    init_inputs();
    test_reset();
    test_add_port0();
    test_port1_sub();
    test_fairness();
    test_stall();
    test_undefined_op();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion want completion");
    $fatal(1);
  end

endmodule
